// File: rtl/p6_mem_responder.sv
// rtl/p6_mem_responder.sv - P6 CPU memory responder: 256x16 RAM, LED register and switch input behind a cmd/ack handshake
// Defining MEM_BUS_ERR_EN adds the err output, flagging unmapped accesses and writes to the switch address.
module p6_mem_responder #(
    parameter int                ADDR_W      = 9,
    parameter int                DATA_W      = 16,
    parameter int                RAM_DEPTH   = 256,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR    = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR     = 9'h140
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              ack,
    output logic              busy,
    input  logic [7:0]        sw,
    output logic [7:0]        ledr
`ifdef MEM_BUS_ERR_EN
   ,output logic              err
`endif
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_ACK
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [2:0]          r_cnt;
    logic [7:0]          r_ledr;
    logic [7:0]          r_sw_meta;
    logic [7:0]          r_sw_sync;
    logic [DATA_W-1:0]   r_ram [RAM_DEPTH];

    logic                w_accept;
    logic                w_access;
    logic                w_in_ram;
    logic                w_is_led;
    logic                w_is_sw;
    logic [RAM_AW-1:0]   w_idx;
    logic [DATA_W-1:0]   w_rd_val;

    assign w_accept = (r_state == S_IDLE) && ((mem_cmd == 2'b01) || (mem_cmd == 2'b10));
    // The access happens on the edge that leaves RESP, so ack rises WAIT_CYCLES+1 edges after acceptance.
    assign w_access = (r_state == S_RESP);
    assign w_in_ram = (int'(r_addr) < RAM_DEPTH);
    assign w_is_led = (r_addr == LED_ADDR);
    assign w_is_sw  = (r_addr == SW_ADDR);
    assign w_idx    = r_addr[RAM_AW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ack    = 1'b0;
        busy   = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_ACK;
            end
            S_ACK: begin
                ack    = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_val = '0;
        if (w_in_ram) begin
            w_rd_val = r_ram[w_idx];
        end else if (w_is_led) begin
            w_rd_val = {{(DATA_W-8){1'b0}}, r_ledr};
        end else if (w_is_sw) begin
            w_rd_val = {{(DATA_W-8){1'b0}}, r_sw_sync};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= 3'd0;
            r_rdata   <= '0;
            r_ledr    <= 8'h00;
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (w_accept) begin
                r_wr    <= (mem_cmd == 2'b10);
                r_addr  <= mem_addr;
                r_wdata <= write_data;
                r_cnt   <= (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
            end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_access) begin
                if (r_wr) begin
                    if (w_is_led) begin
                        r_ledr <= r_wdata[7:0];
                    end
                end else begin
                    r_rdata <= w_rd_val;
                end
            end
        end
    end

    // RAM has no reset; an aborted operation cannot write because reset forces the FSM out of RESP.
    always_ff @(posedge clk) begin
        if (w_access && r_wr && w_in_ram) begin
            r_ram[w_idx] <= r_wdata;
        end
    end

    assign read_data = r_rdata;
    assign ledr      = r_ledr;

`ifdef MEM_BUS_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_access && ((!w_in_ram && !w_is_led && !w_is_sw) || (r_wr && w_is_sw));
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_p6_mem_responder.sv
// tb/tb_p6_mem_responder.sv - randomized self-checking bench for p6_mem_responder (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances)
module tb_p6_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mem_cmd = 2'b00, mem_cmd0 = 2'b00;
    logic [8:0]  mem_addr = '0, mem_addr0 = '0;
    logic [15:0] write_data = '0, write_data0 = '0;
    logic [7:0]  sw = 8'h00, sw0 = 8'h00;
    logic [15:0] read_data, read_data0;
    logic        ack, ack0, busy, busy0;
    logic [7:0]  ledr, ledr0;
`ifdef MEM_BUS_ERR_EN
    logic        err, err0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: memory map as plain arrays
    logic [15:0] m_ram [256];
    logic [7:0]  m_led = 8'h00;
    logic [15:0] m_rd  = 16'h0000;
    logic [7:0]  m_sw  = 8'h00;

    always #5 clk = ~clk;

    p6_mem_responder #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(read_data), .ack(ack), .busy(busy),
        .sw(sw), .ledr(ledr)
`ifdef MEM_BUS_ERR_EN
       ,.err(err)
`endif
    );

    p6_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd0), .mem_addr(mem_addr0),
        .write_data(write_data0), .read_data(read_data0), .ack(ack0), .busy(busy0),
        .sw(sw0), .ledr(ledr0)
`ifdef MEM_BUS_ERR_EN
       ,.err(err0)
`endif
    );

    function automatic logic [15:0] m_read(input logic [8:0] a);
        if (a < 9'd256) return m_ram[a[7:0]];
        if (a == 9'h100) return {8'h00, m_led};
        if (a == 9'h140) return {8'h00, m_sw};
        return 16'h0000;
    endfunction

    task automatic m_apply(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] d);
        if (cmd == 2'b10) begin
            if (a < 9'd256) m_ram[a[7:0]] = d;
            else if (a == 9'h100) m_led = d[7:0];
        end else if (cmd == 2'b01) begin
            m_rd = m_read(a);
        end
    endtask

    // Issues one command on the WAIT_CYCLES=1 instance; returns at the ack cycle (or after a bounded wait).
    task automatic run_op(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] d,
                          output int lat, output logic busy_ok);
        mem_cmd = cmd; mem_addr = a; write_data = d;
        @(posedge clk); #1;
        busy_ok = busy;
        mem_cmd = 2'b00; mem_addr = 9'($urandom); write_data = 16'($urandom);
        lat = -1;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (ledr !== 8'h00) begin n_fail++; $display("FAIL reset_ledr: got %h expected 00", ledr); end
        n_tests++; if (read_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", read_data); end
        n_tests++; if ({ack0, busy0, ledr0, read_data0} !== 26'd0) begin
            n_fail++; $display("FAIL reset_dut0: got ack=%b busy=%b ledr=%h rd=%h expected all 0", ack0, busy0, ledr0, read_data0);
        end
    endtask

    task automatic test_fill;
        int lat; logic bok; logic [15:0] d;
        for (int a = 0; a < 256; a++) begin
            d = 16'($urandom);
            m_apply(2'b10, 9'(a), d);
            run_op(2'b10, 9'(a), d, lat, bok);
            n_tests++; if (lat !== 2 || bok !== 1'b1) begin
                n_fail++; $display("FAIL fill_lat addr=%0d: got lat=%0d busy=%b expected lat=2 busy=1", a, lat, bok);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_read;
        int lat; logic bok;
        m_apply(2'b10, 9'h012, 16'hBEEF);
        run_op(2'b10, 9'h012, 16'hBEEF, lat, bok);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL wr_lat: got %0d expected 2", lat); end
        n_tests++; if (read_data !== m_rd) begin n_fail++; $display("FAIL wr_rdata_held: got %h expected %h", read_data, m_rd); end
        @(posedge clk); #1;
        n_tests++; if (ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_end: got ack=%b busy=%b expected 0 0", ack, busy); end
        m_apply(2'b01, 9'h012, 16'h0);
        run_op(2'b01, 9'h012, 16'h0, lat, bok);
        n_tests++; if (lat !== 2 || bok !== 1'b1) begin n_fail++; $display("FAIL rd_lat: got lat=%0d busy=%b expected 2 1", lat, bok); end
        n_tests++; if (read_data !== 16'hBEEF) begin n_fail++; $display("FAIL rd_beef: got %h expected BEEF", read_data); end
        @(posedge clk); #1;
        n_tests++; if (read_data !== 16'hBEEF) begin n_fail++; $display("FAIL rd_hold: got %h expected BEEF", read_data); end
    endtask

    task automatic test_led_sw;
        int lat; logic bok;
        m_apply(2'b10, 9'h100, 16'h00A5);
        run_op(2'b10, 9'h100, 16'h00A5, lat, bok);
        n_tests++; if (ledr !== 8'hA5) begin n_fail++; $display("FAIL led_write: got %h expected A5", ledr); end
        @(posedge clk); #1;
        sw = 8'h3C; m_sw = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        m_apply(2'b01, 9'h140, 16'h0);
        run_op(2'b01, 9'h140, 16'h0, lat, bok);
        n_tests++; if (read_data !== 16'h003C) begin n_fail++; $display("FAIL sw_read: got %h expected 003C", read_data); end
        @(posedge clk); #1;
        m_apply(2'b01, 9'h100, 16'h0);
        run_op(2'b01, 9'h100, 16'h0, lat, bok);
        n_tests++; if (read_data !== 16'h00A5) begin n_fail++; $display("FAIL led_read: got %h expected 00A5", read_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_unmapped;
        int lat; logic bok;
        m_apply(2'b01, 9'h1F0, 16'h0);
        run_op(2'b01, 9'h1F0, 16'h0, lat, bok);
        n_tests++; if (read_data !== 16'h0000) begin n_fail++; $display("FAIL unmap_read: got %h expected 0000", read_data); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL unmap_lat: got %0d expected 2", lat); end
        @(posedge clk); #1;
        m_apply(2'b10, 9'h1F0, 16'hFFFF);
        run_op(2'b10, 9'h1F0, 16'hFFFF, lat, bok);
        n_tests++; if (ledr !== m_led) begin n_fail++; $display("FAIL unmap_wr_led: got %h expected %h", ledr, m_led); end
        @(posedge clk); #1;
        m_apply(2'b01, 9'h0F0, 16'h0);
        run_op(2'b01, 9'h0F0, 16'h0, lat, bok);
        n_tests++; if (read_data !== m_rd) begin n_fail++; $display("FAIL unmap_wr_alias: got %h expected %h", read_data, m_rd); end
        @(posedge clk); #1;
        m_apply(2'b10, 9'h140, 16'h5555);
        run_op(2'b10, 9'h140, 16'h5555, lat, bok);
        @(posedge clk); #1;
        m_apply(2'b01, 9'h140, 16'h0);
        run_op(2'b01, 9'h140, 16'h0, lat, bok);
        n_tests++; if (read_data !== {8'h00, m_sw}) begin n_fail++; $display("FAIL sw_write_dropped: got %h expected %h", read_data, {8'h00, m_sw}); end
        @(posedge clk); #1;
    endtask

    task automatic test_reserved;
        mem_cmd = 2'b11; mem_addr = 9'h012; write_data = 16'h0000;
        repeat (3) begin
            @(posedge clk); #1;
            n_tests++; if (busy !== 1'b0 || ack !== 1'b0) begin
                n_fail++; $display("FAIL reserved_cmd: got busy=%b ack=%b expected 0 0", busy, ack);
            end
        end
        mem_cmd = 2'b00;
    endtask

    task automatic test_random;
        int lat; logic bok; int k; logic [8:0] a; logic [1:0] c; logic [15:0] d;
        logic exp_err;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                sw = 8'($urandom); m_sw = sw;
                repeat (3) @(posedge clk);
                #1;
            end
            k = $urandom_range(0, 8);
            if (k <= 5) a = 9'($urandom_range(0, 255));
            else if (k == 6) a = 9'h100;
            else if (k == 7) a = 9'h140;
            else begin
                do a = 9'($urandom_range(257, 511)); while (a == 9'h140);
            end
            c = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            d = 16'($urandom);
            exp_err = (a > 9'h0FF && a != 9'h100 && a != 9'h140) || (c == 2'b10 && a == 9'h140);
            m_apply(c, a, d);
            run_op(c, a, d, lat, bok);
            n_tests++; if (lat !== 2 || bok !== 1'b1) begin
                n_fail++; $display("FAIL rand_lat i=%0d: got lat=%0d busy=%b expected 2 1", i, lat, bok);
            end
            n_tests++; if (read_data !== m_rd) begin
                n_fail++; $display("FAIL rand_rdata i=%0d cmd=%b addr=%h: got %h expected %h", i, c, a, read_data, m_rd);
            end
            n_tests++; if (ledr !== m_led) begin
                n_fail++; $display("FAIL rand_ledr i=%0d: got %h expected %h", i, ledr, m_led);
            end
`ifdef MEM_BUS_ERR_EN
            n_tests++; if (err !== exp_err) begin
                n_fail++; $display("FAIL rand_err i=%0d: got %b expected %b", i, err, exp_err);
            end
`endif
            @(posedge clk); #1;
            n_tests++; if (ack !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL rand_end i=%0d: got ack=%b busy=%b expected 0 0", i, ack, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]  cmds [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
        logic [8:0]  addrs [4] = '{9'h033, 9'h034, 9'h033, 9'h034};
        logic [15:0] mem0 [2];
        logic [15:0] exp_rd;
        mem0[0] = 16'($urandom); mem0[1] = ~mem0[0];
        for (int i = 0; i < 4; i++) begin
            mem_cmd0 = cmds[i]; mem_addr0 = addrs[i]; write_data0 = mem0[i % 2];
            @(posedge clk); #1;
            n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy i=%0d: got %b expected 1", i, busy0); end
            // Command left asserted with another address during RESP must be ignored
            mem_cmd0 = 2'b01; mem_addr0 = addrs[(i + 1) % 2]; write_data0 = 16'hDEAD;
            @(posedge clk); #1;
            n_tests++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL b2b_lat i=%0d: got ack=%b expected 1", i, ack0); end
            mem_cmd0 = 2'b00;
            if (cmds[i] == 2'b01) begin
                exp_rd = mem0[i % 2];
                n_tests++; if (read_data0 !== exp_rd) begin
                    n_fail++; $display("FAIL b2b_rdata i=%0d: got %h expected %h", i, read_data0, exp_rd);
                end
            end
            @(posedge clk); #1;
            n_tests++; if (ack0 !== 1'b0 || busy0 !== 1'b0) begin
                n_fail++; $display("FAIL b2b_end i=%0d: got ack=%b busy=%b expected 0 0", i, ack0, busy0);
            end
        end
    endtask

    task automatic test_reset_midop;
        int lat; logic bok; logic [15:0] old;
        old = m_ram[8'h20];
        mem_cmd = 2'b10; mem_addr = 9'h020; write_data = 16'h1234;
        @(posedge clk); #1;
        mem_cmd = 2'b00;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midop_busy: got %b expected 1", busy); end
        reset = 1'b0;
        m_led = 8'h00; m_rd = 16'h0000;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_async: got busy=%b expected 0", busy); end
        repeat (3) begin
            @(posedge clk); #1;
            n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL midop_noack: got %b expected 0", ack); end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (ledr !== 8'h00 || read_data !== 16'h0000) begin
            n_fail++; $display("FAIL midop_regs: got ledr=%h rd=%h expected 00 0000", ledr, read_data);
        end
        repeat (3) @(posedge clk);
        #1;
        m_apply(2'b01, 9'h020, 16'h0);
        run_op(2'b01, 9'h020, 16'h0, lat, bok);
        n_tests++; if (read_data !== old) begin n_fail++; $display("FAIL midop_ram: got %h expected %h", read_data, old); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_fill;
        test_write_read;
        test_led_sw;
        test_unmapped;
        test_reserved;
        test_random;
        test_back_to_back;
        test_reset_midop;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
